mod_inverse_n: RTL and testbench

- Computes the modular inverse `inverse = a^-1 mod params.n` using the binary extended Euclidean algorithm, one shift or subtract step per clock.
- It is the inverse-direction companion of the shift-add modular multiplier over n.
- It feeds ECDSA signing (k^-1) and verification (s^-1), where `params.n` is the odd prime group order from `curve_parameters_t`.

---
 rtl/mod_inverse_n.sv | 195 +++++++++++++++++++
 tb/tb_mod_inverse_n.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse_n.sv
// -----------------------------------------------------------------------------
// mod_inverse_n
//   Modular inverse  inverse = a^-1 mod n  using the binary extended Euclidean
//   algorithm. Each clock performs one shift, one subtract or one state change.
//   This is the inverse-direction companion of the shift-add modular multiplier
//   and serves ECDSA signing (k^-1) and verification (s^-1) over the odd prime
//   group order n.
//
// Ports
//   clk      in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset
//   Start    in   request pulse, sampled only in Idle or Finish
//   a        in   WIDTH  value to invert, captured when Start is accepted
//   params   in   WIDTH  group order n (the n field of the curve parameter
//                        record, the only field this block needs); must be odd
//                        and held stable while Busy
//   Busy     out  high from the cycle after Start acceptance until Done rises
//   Done     out  result valid, held until the next accepted Start or reset
//   Error    out  qualified by Done: a mod n == 0 (or watchdog timeout)
//   inverse  out  WIDTH  result in [1, n-1]; 0 when Error
//
// Optional feature
//   MODINV_TIMEOUT_EN : when defined, an 11-bit cycle counter aborts the
//   operation with Error after MAX_CYCLES busy cycles (guards against an even
//   or zero n). When undefined no counter exists and an even n is unsupported.
// -----------------------------------------------------------------------------
module mod_inverse_n #(
  parameter int WIDTH      = 256,
  parameter int MAX_CYCLES = 1100
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] params,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [WIDTH-1:0] inverse
);

  localparam int W1 = WIDTH + 1;

  if (MAX_CYCLES < 1 || MAX_CYCLES > 2047) begin : g_bad_max_cycles
    $error("MAX_CYCLES must fit the 11-bit cycle counter");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_HALVE_U, S_HALVE_V, S_SUB, S_RESULT, S_FINISH
  } state_t;

  state_t           state_q;
  logic [W1-1:0]    u_q, v_q, x1_q, x2_q;
  logic [WIDTH-1:0] res_q;
  logic             res_err_q;
  logic             busy_q, done_q, error_q;
  logic [WIDTH-1:0] inverse_q;
`ifdef MODINV_TIMEOUT_EN
  localparam logic [10:0] CYC_LIM = 11'(MAX_CYCLES - 1);
  logic [10:0]      cyc_q;
`endif

  logic [W1-1:0] n_ext;
  assign n_ext = {1'b0, params};

  // x/2 mod n for x in [0, n-1]: an odd x is made even by adding the odd n.
  // x + n < 2n always fits in WIDTH+1 bits.
  function automatic logic [W1-1:0] half_mod(input logic [W1-1:0] x,
                                             input logic [W1-1:0] n);
    half_mod = x[0] ? ((x + n) >> 1) : (x >> 1);
  endfunction

  // (x - y) mod n for x, y in [0, n-1]; a borrow is repaired by adding n,
  // the wrap-around at WIDTH+1 bits cancels out.
  function automatic logic [W1-1:0] sub_mod(input logic [W1-1:0] x,
                                            input logic [W1-1:0] y,
                                            input logic [W1-1:0] n);
    logic [W1-1:0] d;
    d = x - y;
    if (x < y) d = d + n;
    sub_mod = d;
  endfunction

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      u_q       <= '0;
      v_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      inverse_q <= '0;
`ifdef MODINV_TIMEOUT_EN
      cyc_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (Start) begin
            // Invariants from here on: x1*a == u and x2*a == v (mod n).
            u_q       <= {1'b0, a};
            v_q       <= n_ext;
            x1_q      <= W1'(1);
            x2_q      <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            inverse_q <= '0;
            state_q   <= S_REDUCE;
`ifdef MODINV_TIMEOUT_EN
            cyc_q     <= '0;
`endif
          end
        end
        S_REDUCE: begin
          if (u_q >= n_ext) begin
            u_q <= u_q - n_ext;
          end else if (u_q == '0) begin
            res_q     <= '0;
            res_err_q <= 1'b1;
            state_q   <= S_RESULT;
          end else begin
            state_q <= S_HALVE_U;
          end
        end
        S_HALVE_U: begin
          if (u_q == W1'(1)) begin
            res_q     <= x1_q[WIDTH-1:0];
            res_err_q <= 1'b0;
            state_q   <= S_RESULT;
          end else if (!u_q[0]) begin
            u_q  <= u_q >> 1;
            x1_q <= half_mod(x1_q, n_ext);
          end else begin
            state_q <= S_HALVE_V;
          end
        end
        S_HALVE_V: begin
          if (v_q == W1'(1)) begin
            res_q     <= x2_q[WIDTH-1:0];
            res_err_q <= 1'b0;
            state_q   <= S_RESULT;
          end else if (!v_q[0]) begin
            v_q  <= v_q >> 1;
            x2_q <= half_mod(x2_q, n_ext);
          end else begin
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          // Both u and v are odd here, so the difference is even and the
          // following halving state always makes progress.
          if (u_q >= v_q) begin
            u_q  <= u_q - v_q;
            x1_q <= sub_mod(x1_q, x2_q, n_ext);
          end else begin
            v_q  <= v_q - u_q;
            x2_q <= sub_mod(x2_q, x1_q, n_ext);
          end
          state_q <= S_HALVE_U;
        end
        S_RESULT: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          error_q   <= res_err_q;
          inverse_q <= res_q;
          state_q   <= S_FINISH;
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef MODINV_TIMEOUT_EN
      // Watchdog overrides whatever the working state decided this cycle.
      if (state_q inside {S_REDUCE, S_HALVE_U, S_HALVE_V, S_SUB}) begin
        cyc_q <= cyc_q + 11'd1;
        if (cyc_q == CYC_LIM) begin
          res_q     <= '0;
          res_err_q <= 1'b1;
          state_q   <= S_RESULT;
        end
      end
`endif
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Error   = error_q;
  assign inverse = inverse_q;

endmodule

// File: tb/tb_mod_inverse_n.sv
// -----------------------------------------------------------------------------
// tb_mod_inverse_n
//   Self-checking bench for mod_inverse_n: a table of directed vectors, a few
//   hand-written multi-cycle sequences (reset abort, Start while busy,
//   back-to-back Start from Finish) and randomized operands checked against a
//   modular-arithmetic reference (Fermat exponentiation / product check).
// -----------------------------------------------------------------------------
module tb_mod_inverse_n;

  localparam int W = 256;
  localparam logic [W-1:0] SECP_N =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [W-1:0] SECP_INV2 =
    256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF5D576E7357A4501DDFE92F46681B20A1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] n_in;
  logic         busy, done, err;
  logic [W-1:0] inv;

  mod_inverse_n #(.WIDTH(W), .MAX_CYCLES(2000)) dut (
    .clk     (clk),
    .Reset_n (rst_n),
    .Start   (start),
    .a       (a_in),
    .params  (n_in),
    .Busy    (busy),
    .Done    (done),
    .Error   (err),
    .inverse (inv)
  );

`ifdef MODINV_TIMEOUT_EN
  logic       t_start, t_busy, t_done, t_err;
  logic [7:0] t_a, t_n, t_inv;

  mod_inverse_n #(.WIDTH(8), .MAX_CYCLES(64)) dut_to (
    .clk     (clk),
    .Reset_n (rst_n),
    .Start   (t_start),
    .a       (t_a),
    .params  (t_n),
    .Busy    (t_busy),
    .Done    (t_done),
    .Error   (t_err),
    .inverse (t_inv)
  );
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic, independent of the iterative algorithm.
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  // b^e mod n for small n (exponent below 2^32): Fermat gives b^(n-2) = b^-1.
  function automatic logic [W-1:0] powmod(input logic [W-1:0] b,
                                          input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [W-1:0] r, bb;
    r  = 1;
    bb = b % n;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = mulmod(r, bb, n);
      bb = mulmod(bb, bb, n);
    end
    return r;
  endfunction

  // Pulse Start for one cycle, then wait (bounded) for Done.
  // lat counts rising edges from the accepting edge to Done high.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] a,
                        input int limit, output int lat,
                        output bit busy_ok, output bit timed_out);
    @(negedge clk);
    n_in  = n;
    a_in  = a;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    lat       = 0;
    busy_ok   = 1'b1;
    timed_out = 1'b0;
    while (!done) begin
      if (!busy) busy_ok = 1'b0;
      if (lat >= limit) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done(input int limit, output bit timed_out);
    int c;
    c = 0;
    timed_out = 1'b0;
    while (!done) begin
      if (c >= limit) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] a;
    logic [W-1:0] inv;
    bit           err;
    int           lat_exact;  // 0 = not checked exactly
    int           lat_max;
  } vec_t;

  initial begin
    vec_t     vecs[$];
    int       lat;
    bit       bok, tmo;
    logic [W-1:0] ra, rn, exp_inv;
    int       primes[8];

    vecs.push_back('{n: 7,      a: 3,  inv: 5,         err: 0, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 7,      a: 10, inv: 5,         err: 0, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 7,      a: 1,  inv: 1,         err: 0, lat_exact: 3, lat_max: 20});
    vecs.push_back('{n: 7,      a: 7,  inv: 0,         err: 1, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 7,      a: 0,  inv: 0,         err: 1, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 7,      a: 14, inv: 0,         err: 1, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 7,      a: 6,  inv: 6,         err: 0, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 11,     a: 2,  inv: 6,         err: 0, lat_exact: 0, lat_max: 30});
    vecs.push_back('{n: 3,      a: 2,  inv: 2,         err: 0, lat_exact: 0, lat_max: 20});
    vecs.push_back('{n: 13,     a: 1,  inv: 1,         err: 0, lat_exact: 3, lat_max: 20});
    vecs.push_back('{n: SECP_N, a: 2,  inv: SECP_INV2, err: 0, lat_exact: 0, lat_max: 1100});

    primes = '{3, 5, 7, 11, 13, 101, 251, 65521};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    n_in  = 7;
`ifdef MODINV_TIMEOUT_EN
    t_start = 1'b0;
    t_a     = '0;
    t_n     = 8'd7;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_error", W'(err), 0);
    check("reset_inverse", inv, 0);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].a, vecs[i].lat_max + 5, lat, bok, tmo);
      check($sformatf("vec%0d_timeout", i), W'(tmo), 0);
      check($sformatf("vec%0d_inverse", i), inv, vecs[i].inv);
      check($sformatf("vec%0d_error", i), W'(err), W'(vecs[i].err));
      check($sformatf("vec%0d_busy_while_working", i), W'(bok), 1);
      check($sformatf("vec%0d_busy_low_at_done", i), W'(busy), 0);
      if (vecs[i].lat_exact > 0)
        check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat_exact));
      else
        check($sformatf("vec%0d_latency_bound", i), W'(lat <= vecs[i].lat_max), 1);
    end

    // Reset asserted in the middle of a long operation aborts immediately.
    ra = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom} % SECP_N;
    if (ra == 0) ra = 3;
    @(negedge clk);
    n_in = SECP_N; a_in = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("midop_busy_before_reset", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", W'(busy), 0);
    check("midop_reset_done", W'(done), 0);
    check("midop_reset_error", W'(err), 0);
    check("midop_reset_inverse", inv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(7, 3, 30, lat, bok, tmo);
    check("after_reset_timeout", W'(tmo), 0);
    check("after_reset_inverse", inv, 5);

    // Start pulsed again while busy must be ignored.
    @(negedge clk);
    n_in = 7; a_in = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, tmo);
    check("repulse_timeout", W'(tmo), 0);
    check("repulse_inverse", inv, 5);
    check("repulse_error", W'(err), 0);

    // Back-to-back: Start accepted in Finish, Done drops for a cycle.
    @(negedge clk);
    a_in = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drops", W'(done), 0);
    check("b2b_busy_rises", W'(busy), 1);
    wait_done(40, tmo);
    check("b2b_timeout", W'(tmo), 0);
    check("b2b_inverse", inv, 4);

    // Random small primes, reference by Fermat exponentiation.
    for (int k = 0; k < 150; k++) begin
      rn = W'(primes[$urandom_range(0, 7)]);
      ra = W'($urandom_range(0, 3 * int'(rn) - 1));
      exp_inv = ((ra % rn) == 0) ? W'(0) : powmod(ra, rn - 2, rn);
      run_op(rn, ra, 400, lat, bok, tmo);
      check($sformatf("rnd_small%0d_timeout", k), W'(tmo), 0);
      check($sformatf("rnd_small%0d_inverse n=%0d a=%0d", k, rn, ra), inv, exp_inv);
      check($sformatf("rnd_small%0d_error", k), W'(err), W'((ra % rn) == 0));
    end

    // Random 256-bit operands against the secp256k1 order.
    for (int k = 0; k < 24; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom} % SECP_N;
      if (ra == 0) ra = 1;
      run_op(SECP_N, ra, 2100, lat, bok, tmo);
      check($sformatf("rnd_secp%0d_timeout", k), W'(tmo), 0);
      check($sformatf("rnd_secp%0d_product a=%0h", k, ra), mulmod(ra, inv, SECP_N), 1);
      check($sformatf("rnd_secp%0d_range", k), W'(inv < SECP_N && inv != 0), 1);
      check($sformatf("rnd_secp%0d_error", k), W'(err), 0);
    end

`ifdef MODINV_TIMEOUT_EN
    // Watchdog instance: an even n must still bring the block to Done.
    begin
      int c;
      @(negedge clk);
      t_n = 8'd8; t_a = 8'd3; t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      c = 0;
      while (!t_done && c < 80) begin
        @(negedge clk);
        c++;
      end
      check("watchdog_done", W'(t_done), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
